// File: rtl/pipelined_rca_fault_checker_if.sv
// Operand/result bus of the pipelined ripple-carry fault checker.
//   master : drives operands, fault controls and out_ready; sees in_ready and results
//   slave  : the adder, the opposite directions
interface pipelined_rca_fault_checker_if #(
  parameter int unsigned WIDTH = 8
);
  localparam int unsigned PW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             fault_en;
  logic [PW-1:0]    fault_pos;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   golden;
  logic             mismatch;

  modport master (
    output in_valid, a, b, cin, fault_en, fault_pos, out_ready,
    input  in_ready, out_valid, sum, golden, mismatch
  );

  modport slave (
    input  in_valid, a, b, cin, fault_en, fault_pos, out_ready,
    output in_ready, out_valid, sum, golden, mismatch
  );
endinterface

// File: rtl/pipelined_rca_fault_checker.sv
// Pipelined ripple-carry adder with one runtime-selectable faulty full-adder
// cell. A golden a+b+cin travels with every transaction and each result is
// flagged when the ripple sum disagrees with it. Saturating counters track
// completed and mismatching transactions.
// Ports:
//   clk, rst_n      clock (rising edge), asynchronous active-low reset
//   bus (slave)     in_valid/in_ready, a, b, cin, fault_en, fault_pos,
//                   out_valid/out_ready, sum, golden, mismatch
//   clr_counts      synchronous clear of both counters (wins over increment)
//   op_count        completed transactions (saturating)
//   err_count       completed transactions with mismatch=1 (saturating)
// WIDTH must be divisible by STAGES.
module pipelined_rca_fault_checker #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned STAGES = 2,
  parameter int unsigned CNT_W  = 16
) (
  input  logic                              clk,
  input  logic                              rst_n,
  pipelined_rca_fault_checker_if.slave      bus,
  input  logic                              clr_counts,
  output logic [CNT_W-1:0]                  op_count,
  output logic [CNT_W-1:0]                  err_count
);

  localparam int unsigned SW = WIDTH / STAGES;
  localparam int unsigned PW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  // Pipeline register p[s] feeds stage s; p[0] is loaded at acceptance.
  logic [STAGES-1:0] pv;
  logic [WIDTH-1:0]  pa   [STAGES];
  logic [WIDTH-1:0]  pb   [STAGES];
  logic [WIDTH-1:0]  ps   [STAGES];
  logic              pc   [STAGES];
  logic [WIDTH:0]    pg   [STAGES];
  logic              pfe  [STAGES];
  logic [PW-1:0]     pfp  [STAGES];

  // Combinational result of each stage.
  logic [WIDTH-1:0]  nsum [STAGES];
  logic              ncar [STAGES];
  logic [SW:0]       slice;

  logic adv;
  logic hs;
  logic [WIDTH:0] final_sum;

  assign adv          = !bus.out_valid || bus.out_ready;
  assign bus.in_ready = adv;
  assign hs           = bus.out_valid && bus.out_ready;

  // One slice of full-adder cells; the faulty cell inverts its sum only.
  // fault_pos >= WIDTH never equals a real bit index, so no cell is faulty.
  function automatic logic [SW:0] cell_slice(
    input logic [SW-1:0] sa,
    input logic [SW-1:0] sb,
    input logic          c_in,
    input logic          fen,
    input logic [PW-1:0] fp,
    input int unsigned   base
  );
    logic          c;
    logic          x;
    logic [SW-1:0] s;
    c = c_in;
    s = '0;
    for (int unsigned j = 0; j < SW; j++) begin
      x = sa[j] ^ sb[j] ^ c;
      if (fen && (fp == PW'(base + j))) x = ~x;
      s[j] = x;
      c = (sa[j] & sb[j]) | (sa[j] & c) | (sb[j] & c);
    end
    return {c, s};
  endfunction

  always_comb begin
    nsum  = '{default: '0};
    ncar  = '{default: 1'b0};
    slice = '0;
    for (int unsigned s = 0; s < STAGES; s++) begin
      slice   = cell_slice(pa[s][s*SW +: SW], pb[s][s*SW +: SW], pc[s],
                           pfe[s], pfp[s], s * SW);
      nsum[s] = ps[s];
      nsum[s][s*SW +: SW] = slice[SW-1:0];
      ncar[s] = slice[SW];
    end
  end

  assign final_sum = {ncar[STAGES-1], nsum[STAGES-1]};

  // Whole pipeline advances together on adv; a stall freezes every stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pv           <= '0;
      bus.out_valid <= 1'b0;
      bus.sum      <= '0;
      bus.golden   <= '0;
      bus.mismatch <= 1'b0;
      for (int unsigned s = 0; s < STAGES; s++) begin
        pa[s]  <= '0;
        pb[s]  <= '0;
        ps[s]  <= '0;
        pc[s]  <= 1'b0;
        pg[s]  <= '0;
        pfe[s] <= 1'b0;
        pfp[s] <= '0;
      end
    end else if (adv) begin
      pv[0]  <= bus.in_valid;
      pa[0]  <= bus.a;
      pb[0]  <= bus.b;
      ps[0]  <= '0;
      pc[0]  <= bus.cin;
      pg[0]  <= {1'b0, bus.a} + {1'b0, bus.b} + {{WIDTH{1'b0}}, bus.cin};
      pfe[0] <= bus.fault_en;
      pfp[0] <= bus.fault_pos;
      for (int unsigned s = 1; s < STAGES; s++) begin
        pv[s]  <= pv[s-1];
        pa[s]  <= pa[s-1];
        pb[s]  <= pb[s-1];
        ps[s]  <= nsum[s-1];
        pc[s]  <= ncar[s-1];
        pg[s]  <= pg[s-1];
        pfe[s] <= pfe[s-1];
        pfp[s] <= pfp[s-1];
      end
      bus.out_valid <= pv[STAGES-1];
      bus.sum      <= final_sum;
      bus.golden   <= pg[STAGES-1];
      bus.mismatch <= (final_sum != pg[STAGES-1]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_count  <= '0;
      err_count <= '0;
    end else if (clr_counts) begin
      op_count  <= '0;
      err_count <= '0;
    end else if (hs) begin
      if (op_count != '1) op_count <= op_count + 1'b1;
      if (bus.mismatch && (err_count != '1)) err_count <= err_count + 1'b1;
    end
  end

endmodule

// File: doc/pipelined_rca_fault_checker.md
Name: pipelined_rca_fault_checker

Overview:
- Parametrised, pipelined ripple-carry adder built from full-adder cells.
- One runtime-selectable cell can be replaced by a faulty cell to inject a fault.
- A golden sum travels alongside each transaction, so every result is compared and flagged on a mismatch.
- Running operation and error counters are kept; the block is the successor of the fixed 8-bit single-fault adder bench and is used for fault-detection experiments.

Parameters:
- WIDTH, 8: operand width in bits; sum is WIDTH+1 bits.
- STAGES, 2: pipeline stages. WIDTH must be divisible by STAGES; each stage holds WIDTH/STAGES full-adder cells.
- CNT_W, 16: width of the saturating counters.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  input operands are valid.
- in_ready  out  1  block accepts input this cycle.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- cin  in  1  carry in.
- fault_en  in  1  enables fault injection for this transaction.
- fault_pos  in  $clog2(WIDTH)  bit index of the faulty cell.
- out_valid  out  1  result is valid.
- out_ready  in  1  downstream accepts the result.
- sum  out  WIDTH+1  ripple result, including injected fault; MSB is carry out.
- golden  out  WIDTH+1  reference a+b+cin.
- mismatch  out  1  sum != golden; meaningful only when out_valid=1.
- clr_counts  in  1  synchronous clear of both counters.
- op_count  out  CNT_W  completed transactions.
- err_count  out  CNT_W  completed transactions with mismatch=1.

Behaviour:
- Reset (rst_n=0, asynchronous): all pipeline valid bits, out_valid, sum, golden, mismatch, op_count and err_count go to 0. Reset mid-transaction discards all in-flight data. First acceptance is possible on the first rising edge after rst_n deasserts.
- Flow control:
  - Global pipeline enable: adv = !out_valid || out_ready.
  - in_ready = adv, combinational.
  - Input is accepted on a rising edge when in_valid && in_ready.
  - Stalls freeze every stage, and the outputs hold stable.
  - No bubbles are collapsed; the pipeline advances as a whole.
- Latency and throughput:
  - Latency is exactly STAGES cycles from acceptance to out_valid.
  - Throughput is 1 transaction per cycle when out_ready=1.
- Datapath, per stage s (0..STAGES-1):
  - The stage processes bits [s*W/S +: W/S] using the carry registered from stage s-1 (stage 0 uses cin).
  - Unprocessed upper operand bits, already-computed lower sum bits, the golden value and the fault controls are pipelined alongside.
- Full-adder cell:
  - Correct cell: sum = a^b^c, cout = ab | ac | bc.
  - Faulty cell: sum = ~(a^b^c), cout unchanged.
  - The faulty cell is used at bit i iff fault_en=1 and fault_pos==i, using the values captured at acceptance.
  - fault_pos >= WIDTH means no cell is faulty.
- Golden: computed at acceptance as the (WIDTH+1)-bit a+b+cin and delayed STAGES cycles.
- mismatch: registered together with sum/golden; equals (sum != golden).
- Counters: update on output handshake (out_valid && out_ready).
  - op_count increments by 1 on each handshake.
  - err_count increments by 1 on a handshake when mismatch=1.
  - Both saturate at 2^CNT_W-1; there is no wrap-around.
  - clr_counts=1 sets both counters to 0 on the next edge, with priority over a simultaneous increment.
- Simultaneous accept and output handshake in the same cycle is legal and required for full throughput.

Test Plan:
- No fault: a=100, b=55, cin=0 -> after 2 cycles out_valid=1, sum=155, golden=155, mismatch=0, op_count=1, err_count=0.
- Fault at bit 2: a=3, b=1, cin=0, fault_en=1, fault_pos=2 -> sum=0, golden=4, mismatch=1, err_count=1.
- Carry extremes: a=255, b=255, cin=1 -> sum=511 (MSB set), golden=511, mismatch=0. With fault_pos=7: sum=383, mismatch=1.
- Backpressure: stream 4 back-to-back operations with out_ready=0 for 3 cycles after the first result.
  - in_ready=0 while stalled; sum holds its value.
  - All 4 results emerge in order with none lost or duplicated.
  - op_count=4 at the end.
- Saturation and clear: with CNT_W=2, perform 5 faulty transactions -> err_count=3, op_count=3. Then assert clr_counts in the same cycle as a handshake -> both counters are 0.
- Reset mid-flight: accept 2 operations, then pull rst_n low asynchronously between edges -> out_valid=0 immediately and counters=0. After release, no stale result appears.
